// File: rtl/hwpe_stream_package.sv
// Shared constants and helpers for the HWPE TCDM streaming blocks.
//   HWPE_TCDM_*_W                  : TCDM bus field widths
//   HWPE_TCDM_RESP_LATENCY_DEFAULT : default memory response latency in cycles
//   rr_next()                      : round-robin successor of an index, wrapping at n
package hwpe_stream_package;

   localparam int unsigned HWPE_TCDM_ADDR_W = 32;
   localparam int unsigned HWPE_TCDM_DATA_W = 32;
   localparam int unsigned HWPE_TCDM_BE_W   = HWPE_TCDM_DATA_W / 8;

   localparam int unsigned HWPE_TCDM_RESP_LATENCY_DEFAULT = 1;

   // Explicit compare-and-wrap so a non-power-of-two n works.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/hwpe_stream_intf_tcdm.sv
// TCDM request/response bundle between a requester (master) and a memory port (slave).
//   req/gnt        : request handshake
//   add/wen/be/data: address, write-enable (1 = read, 0 = write), byte enables, write data
//   r_data/r_valid : response, one per accepted request
interface hwpe_stream_intf_tcdm;
   import hwpe_stream_package::*;

   logic                        req;
   logic                        gnt;
   logic [HWPE_TCDM_ADDR_W-1:0] add;
   logic                        wen;
   logic [HWPE_TCDM_BE_W-1:0]   be;
   logic [HWPE_TCDM_DATA_W-1:0] data;
   logic [HWPE_TCDM_DATA_W-1:0] r_data;
   logic                        r_valid;

   modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
   modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);

endinterface

// File: rtl/hwpe_stream_rr_pick.sv
// Combinational round-robin picker.
//   req         : request vector
//   ptr         : highest-priority index this cycle
//   win_idx_c   : first requesting index scanning ptr..NB_IN-1, 0..ptr-1
//   win_valid_c : at least one request is active
module hwpe_stream_rr_pick #(
   parameter  int unsigned NB_IN = 2,
   localparam int unsigned IDX_W = $clog2(NB_IN)
) (
   input  logic [NB_IN-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] win_idx_c,
   output logic             win_valid_c
);

   // Two linear passes instead of a modulo rotation: indices at/above ptr
   // first, then the wrapped-around indices below ptr.
   always_comb begin
      win_idx_c   = '0;
      win_valid_c = 1'b0;
      for (int unsigned i = 0; i < NB_IN; i++) begin
         if (!win_valid_c && req[i] && (IDX_W'(i) >= ptr)) begin
            win_valid_c = 1'b1;
            win_idx_c   = IDX_W'(i);
         end
      end
      for (int unsigned i = 0; i < NB_IN; i++) begin
         if (!win_valid_c && req[i]) begin
            win_valid_c = 1'b1;
            win_idx_c   = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/hwpe_stream_tcdm_rr_arbiter.sv
// Round-robin arbiter sharing one TCDM memory port among NB_IN requesters.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   clear_i       : synchronous soft clear, same effect as reset
//   enable_i      : when low no request is forwarded to the memory port
//   in[NB_IN]     : requester ports (slave side)
//   out           : shared memory port (master side)
//   busy_o        : some accepted transaction still awaits its response
//   err_o         : sticky, a memory response arrived with no in-flight tag
// Requests pass through with zero latency; responses are steered back by a
// RESP_LATENCY-deep tag pipeline that follows the fixed memory latency.
module hwpe_stream_tcdm_rr_arbiter
   import hwpe_stream_package::*;
#(
   parameter int unsigned NB_IN        = 2,
   parameter int unsigned RESP_LATENCY = HWPE_TCDM_RESP_LATENCY_DEFAULT
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                clear_i,
   input  logic                enable_i,
   hwpe_stream_intf_tcdm.slave  in [NB_IN-1:0],
   hwpe_stream_intf_tcdm.master out,
   output logic                busy_o,
   output logic                err_o
);

   localparam int unsigned IDX_W = $clog2(NB_IN);

   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
   } tcdm_inflight_t;

   logic [NB_IN-1:0]            req_v;
   logic [NB_IN-1:0]            wen_v;
   logic [HWPE_TCDM_ADDR_W-1:0] add_a  [NB_IN];
   logic [HWPE_TCDM_BE_W-1:0]   be_a   [NB_IN];
   logic [HWPE_TCDM_DATA_W-1:0] data_a [NB_IN];

   logic [HWPE_TCDM_ADDR_W-1:0] out_add_c;
   logic                        out_wen_c;
   logic [HWPE_TCDM_BE_W-1:0]   out_be_c;
   logic [HWPE_TCDM_DATA_W-1:0] out_data_c;

   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] ptr_d;
   logic [IDX_W-1:0] win_idx_c;
   logic             win_valid_c;
   logic             out_req_c;
   logic             accept_c;

   tcdm_inflight_t pipe_q [RESP_LATENCY];
   tcdm_inflight_t stage0_c;
   tcdm_inflight_t tail_c;
   logic           err_q;

   // Flatten the interface array so the mux can use a run-time index.
   for (genvar g = 0; g < NB_IN; g++) begin : g_port
      assign req_v[g]     = in[g].req;
      assign wen_v[g]     = in[g].wen;
      assign add_a[g]     = in[g].add;
      assign be_a[g]      = in[g].be;
      assign data_a[g]    = in[g].data;
      assign in[g].gnt     = accept_c && win_valid_c && (win_idx_c == IDX_W'(g));
      assign in[g].r_valid = out.r_valid && tail_c.valid && (tail_c.idx == IDX_W'(g));
      assign in[g].r_data  = out.r_data;
   end

   hwpe_stream_rr_pick #(
      .NB_IN (NB_IN)
   ) i_pick (
      .req         (req_v),
      .ptr         (ptr_q),
      .win_idx_c   (win_idx_c),
      .win_valid_c (win_valid_c)
   );

   assign out_req_c = enable_i && (|req_v);
   assign accept_c  = out_req_c && out.gnt;

   // Winner payload mux; zero when nobody requests.
   always_comb begin
      out_add_c  = '0;
      out_wen_c  = 1'b0;
      out_be_c   = '0;
      out_data_c = '0;
      if (win_valid_c) begin
         out_add_c  = add_a[win_idx_c];
         out_wen_c  = wen_v[win_idx_c];
         out_be_c   = be_a[win_idx_c];
         out_data_c = data_a[win_idx_c];
      end
   end

   assign out.req  = out_req_c;
   assign out.add  = out_add_c;
   assign out.wen  = out_wen_c;
   assign out.be   = out_be_c;
   assign out.data = out_data_c;

   // Pointer moves past the winner only on an accepted request.
   always_comb begin
      ptr_d = ptr_q;
      if (accept_c) begin
         ptr_d = IDX_W'(rr_next(32'(win_idx_c), NB_IN));
      end
   end

   // Tag entering the in-flight pipeline this cycle.
   always_comb begin
      stage0_c.valid = accept_c;
      stage0_c.idx   = accept_c ? win_idx_c : '0;
   end

   assign tail_c = pipe_q[RESP_LATENCY-1];

   // Pointer, tag pipeline and error flag.
   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         ptr_q <= '0;
         err_q <= 1'b0;
         for (int unsigned s = 0; s < RESP_LATENCY; s++) begin
            pipe_q[s] <= '0;
         end
      end else begin
         ptr_q     <= ptr_d;
         pipe_q[0] <= stage0_c;
         for (int unsigned s = 1; s < RESP_LATENCY; s++) begin
            pipe_q[s] <= pipe_q[s-1];
         end
         if (out.r_valid && !tail_c.valid) begin
            err_q <= 1'b1;
         end
      end
   end

   // Busy while any tag is still travelling towards its response.
   always_comb begin
      busy_o = 1'b0;
      for (int unsigned s = 0; s < RESP_LATENCY; s++) begin
         busy_o = busy_o | pipe_q[s].valid;
      end
   end

   assign err_o = err_q;

endmodule

// File: tb/tb_hwpe_stream_tcdm_rr_arbiter.sv
// Bench for hwpe_stream_tcdm_rr_arbiter with NB_IN=3, RESP_LATENCY=3.
// Directed stimulus pushes expected grants/responses into queues; a negedge
// monitor pops and compares whenever the DUT presents a gnt or r_valid.
module tb_hwpe_stream_tcdm_rr_arbiter;

   localparam int unsigned NB_IN = 3;
   localparam int unsigned LAT   = 3;

   typedef struct {
      int          idx;
      logic [31:0] data;
   } rsp_t;

   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic rst_ni, clear_i, enable_i, busy_o, err_o;
   logic [NB_IN-1:0] req, wen, gnt, r_valid;
   logic [31:0] add    [NB_IN];
   logic [31:0] wdata  [NB_IN];
   logic [31:0] r_data [NB_IN];

   logic        mem_gnt, spur, mem_rst;
   logic [31:0] mem [64];
   logic        mv  [LAT];
   logic [31:0] md  [LAT];

   int   gnt_q[$];
   rsp_t rsp_q[$];
   int   total = 0;
   int   bad   = 0;

   hwpe_stream_intf_tcdm tcdm_in [NB_IN-1:0] ();
   hwpe_stream_intf_tcdm tcdm_out ();

   for (genvar g = 0; g < NB_IN; g++) begin : g_port
      assign tcdm_in[g].req  = req[g];
      assign tcdm_in[g].add  = add[g];
      assign tcdm_in[g].wen  = wen[g];
      assign tcdm_in[g].be   = 4'hF;
      assign tcdm_in[g].data = wdata[g];
      assign gnt[g]          = tcdm_in[g].gnt;
      assign r_valid[g]      = tcdm_in[g].r_valid;
      assign r_data[g]       = tcdm_in[g].r_data;
   end

   assign tcdm_out.gnt     = mem_gnt;
   assign tcdm_out.r_valid = mv[LAT-1] | spur;
   assign tcdm_out.r_data  = md[LAT-1];

   hwpe_stream_tcdm_rr_arbiter #(
      .NB_IN        (NB_IN),
      .RESP_LATENCY (LAT)
   ) i_dut (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (clear_i),
      .enable_i (enable_i),
      .in       (tcdm_in),
      .out      (tcdm_out),
      .busy_o   (busy_o),
      .err_o    (err_o)
   );

   // Memory model: fixed LAT-cycle response; writes answer with 0. Not reset by rst_ni.
   always @(posedge clk_i) begin : mem_model
      logic acc;
      acc = tcdm_out.req && tcdm_out.gnt;
      if (mem_rst) begin
         for (int i = 0; i < 64; i++) mem[i] = 32'h0;
         mem[4]  = 32'hDEADBEEF;
         mem[16] = 32'h1000_0000;
         mem[17] = 32'h1111_1111;
         mem[18] = 32'h2222_2222;
         for (int s = 0; s < LAT; s++) begin
            mv[s] <= 1'b0;
            md[s] <= 32'h0;
         end
      end else begin
         mv[0] <= acc;
         md[0] <= (acc && tcdm_out.wen) ? mem[tcdm_out.add[7:2]] : 32'h0;
         if (acc && !tcdm_out.wen) mem[tcdm_out.add[7:2]] = tcdm_out.data;
         for (int s = 1; s < LAT; s++) begin
            mv[s] <= mv[s-1];
            md[s] <= md[s-1];
         end
      end
   end

   // Monitor: compare every presented grant and response against the queues.
   always @(negedge clk_i) begin : mon
      int   ng, nr, gi, ri, eg;
      rsp_t er;
      ng = 0; nr = 0; gi = 0; ri = 0;
      for (int i = 0; i < NB_IN; i++) begin
         if (gnt[i] === 1'b1)     begin ng++; gi = i; end
         if (r_valid[i] === 1'b1) begin nr++; ri = i; end
      end
      if (ng > 1) begin
         total++; bad++;
         $display("FAIL multi_gnt actual=%b required=one-hot", gnt);
      end else if (ng == 1) begin
         total++;
         if (gnt_q.size() == 0) begin
            bad++;
            $display("FAIL gnt_unexpected actual=port%0d required=none t=%0t", gi, $time);
         end else begin
            eg = gnt_q.pop_front();
            if (eg != gi) begin
               bad++;
               $display("FAIL gnt_order actual=port%0d required=port%0d t=%0t", gi, eg, $time);
            end
         end
      end
      if (nr > 1) begin
         total++; bad++;
         $display("FAIL multi_rvalid actual=%b required=one-hot", r_valid);
      end else if (nr == 1) begin
         total++;
         if (rsp_q.size() == 0) begin
            bad++;
            $display("FAIL rvalid_unexpected actual=port%0d required=none t=%0t", ri, $time);
         end else begin
            er = rsp_q.pop_front();
            if (er.idx != ri || r_data[ri] !== er.data) begin
               bad++;
               $display("FAIL rsp actual=port%0d/0x%08h required=port%0d/0x%08h t=%0t",
                        ri, r_data[ri], er.idx, er.data, $time);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic exp_rsp(input int idx, input logic [31:0] data);
      rsp_t r;
      r.idx  = idx;
      r.data = data;
      rsp_q.push_back(r);
   endtask

   task automatic drain(input string name);
      repeat (6) tick();
      check({name, "_gnt_q"}, 32'(gnt_q.size()), 32'd0);
      check({name, "_rsp_q"}, 32'(rsp_q.size()), 32'd0);
   endtask

   initial begin
      rst_ni = 1'b0; clear_i = 1'b0; enable_i = 1'b1;
      mem_gnt = 1'b1; spur = 1'b0; mem_rst = 1'b1;
      req = '0; wen = '1;
      for (int i = 0; i < NB_IN; i++) begin
         add[i] = 32'h0; wdata[i] = 32'h0;
      end
      tick(); tick();
      mem_rst = 1'b0;
      check("rst_out_req", 32'(tcdm_out.req), 32'd0);
      check("rst_gnt",     32'(gnt), 32'd0);
      check("rst_rvalid",  32'(r_valid), 32'd0);
      check("rst_busy",    32'(busy_o), 32'd0);
      check("rst_err",     32'(err_o), 32'd0);
      rst_ni = 1'b1;
      tick();

      // Single requester: port 1 reads 0x10, response after LAT cycles.
      add[1] = 32'h10; req[1] = 1'b1;
      gnt_q.push_back(1); exp_rsp(1, 32'hDEADBEEF);
      #1;
      check("s1_out_add", tcdm_out.add, 32'h10);
      tick();
      req[1] = 1'b0;
      #1;
      check("s1_busy", 32'(busy_o), 32'd1);
      tick();
      check("s1_rvalid_early", 32'(r_valid), 32'd0);
      tick();
      check("s1_rvalid", 32'(r_valid), 32'h2);
      check("s1_rdata", r_data[1], 32'hDEADBEEF);
      drain("s1");

      // All three request continuously from ptr=0 after a clear.
      clear_i = 1'b1; tick(); clear_i = 1'b0;
      add[0] = 32'h40; add[1] = 32'h44; add[2] = 32'h48;
      req = 3'b111;
      for (int k = 0; k < 6; k++) gnt_q.push_back(k % 3);
      exp_rsp(0, 32'h1000_0000); exp_rsp(1, 32'h1111_1111); exp_rsp(2, 32'h2222_2222);
      exp_rsp(0, 32'h1000_0000); exp_rsp(1, 32'h1111_1111); exp_rsp(2, 32'h2222_2222);
      for (int k = 0; k < 6; k++) begin
         tick();
         check("s2_busy", 32'(busy_o), 32'd1);
      end
      req = '0;
      drain("s2");

      // Memory stall on ports 0 and 2: no grant until gnt returns.
      mem_gnt = 1'b0;
      req[0] = 1'b1; req[2] = 1'b1;
      #1;
      check("s3_out_req", 32'(tcdm_out.req), 32'd1);
      repeat (3) tick();
      mem_gnt = 1'b1;
      gnt_q.push_back(0); exp_rsp(0, 32'h1000_0000);
      gnt_q.push_back(2); exp_rsp(2, 32'h2222_2222);
      tick();
      req[0] = 1'b0;
      tick();
      req[2] = 1'b0;
      drain("s3");

      // Write by port 1 then read of the same word by port 0; order preserved.
      add[1] = 32'h20; wen[1] = 1'b0; wdata[1] = 32'h1234_5678; req[1] = 1'b1;
      gnt_q.push_back(1); exp_rsp(1, 32'h0);
      tick();
      req[1] = 1'b0; wen[1] = 1'b1;
      add[0] = 32'h20; req[0] = 1'b1;
      gnt_q.push_back(0); exp_rsp(0, 32'h1234_5678);
      tick();
      req[0] = 1'b0;
      check("s4_rvalid_early", 32'(r_valid), 32'd0);
      tick();
      check("s4_wr_rvalid", 32'(r_valid), 32'h2);
      tick();
      check("s4_rd_rvalid", 32'(r_valid), 32'h1);
      check("s4_rd_data", r_data[0], 32'h1234_5678);
      drain("s4");

      // enable_i drops with a response in flight; it still routes.
      add[2] = 32'h48; req[2] = 1'b1;
      gnt_q.push_back(2); exp_rsp(2, 32'h2222_2222);
      tick();
      req[2] = 1'b0; enable_i = 1'b0; req[0] = 1'b1; add[0] = 32'h40;
      #1;
      check("s5_out_req_off", 32'(tcdm_out.req), 32'd0);
      repeat (3) tick();
      check("s5_out_req_off2", 32'(tcdm_out.req), 32'd0);
      req[0] = 1'b0; enable_i = 1'b1;
      drain("s5");

      // Spurious memory response: dropped, err sticky until clear.
      spur = 1'b1;
      #1;
      check("s6_no_rvalid", 32'(r_valid), 32'd0);
      tick();
      spur = 1'b0;
      check("s6_err_set", 32'(err_o), 32'd1);
      tick(); tick();
      check("s6_err_sticky", 32'(err_o), 32'd1);
      clear_i = 1'b1; tick(); clear_i = 1'b0;
      check("s6_err_clr", 32'(err_o), 32'd0);

      // Reset with two reads in flight; ptr would otherwise be 2.
      add[0] = 32'h40; req[0] = 1'b1;
      gnt_q.push_back(0);
      tick();
      req[0] = 1'b0; add[1] = 32'h44; req[1] = 1'b1;
      gnt_q.push_back(1);
      tick();
      req[1] = 1'b0; rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      check("s7_busy_rst", 32'(busy_o), 32'd0);
      check("s7_err_rst", 32'(err_o), 32'd0);
      add[2] = 32'h48; req[1] = 1'b1; req[2] = 1'b1;
      gnt_q.push_back(1); exp_rsp(1, 32'h1111_1111);
      tick();
      req[1] = 1'b0;
      gnt_q.push_back(2); exp_rsp(2, 32'h2222_2222);
      check("s7_err_orphan", 32'(err_o), 32'd1);
      tick();
      req[2] = 1'b0;
      drain("s7");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hwpe_stream_tcdm_rr_arbiter.md
Name: hwpe_stream_tcdm_rr_arbiter

Overview:
- Shares one TCDM memory port among NB_IN TCDM requesters using round-robin arbitration.
- Sits between the HWPE streamer's TCDM masters and a single memory bank, or the bench memory model in simulation.
- Forwards the winning request with zero added latency.
- Routes each response back to the originating requester through an in-flight tracking pipeline of depth RESP_LATENCY.

Parameters:
- NB_IN, default 2: number of requester ports; must be >= 2.
- RESP_LATENCY, default 1: fixed cycles from accepted request (req & gnt) to r_valid on the memory side; must be >= 1.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  reset, synchronous, active-low.
- clear_i  input  1  synchronous soft clear; same effect as reset.
- enable_i  input  1  when low, no requests are forwarded to out.
- in  slave hwpe_stream_intf_tcdm  [NB_IN-1:0]  requester ports (req, gnt, add, wen, be, data, r_data, r_valid).
- out  master hwpe_stream_intf_tcdm  1  shared memory port.
- busy_o  output  1  high while any accepted transaction awaits its response.
- err_o  output  1  sticky; set when out.r_valid arrives with no matching in-flight entry.

Behaviour:
- Reset (rst_ni=0 at clock edge) or clear_i=1:
  - priority pointer <= 0.
  - In-flight pipeline cleared to all-invalid.
  - err_o <= 0; busy_o reads 0 the following cycle.
- Outputs during and right after reset: out.req=0 while no in.req is high; all in.gnt=0; all in.r_valid=0.
- Winner selection (combinational):
  - First index i with in[i].req=1, scanning ptr, ptr+1, ..., NB_IN-1, 0, ..., ptr-1.
  - No requester active: no winner.
- Request forwarding:
  - out.req = enable_i & any in.req.
  - out.add, wen, be and data come from the winner; they are 0 when there is no winner.
- Grant: in[w].gnt = out.gnt & out.req for winner w; all other in[i].gnt=0.
- Accept event: out.req & out.gnt.
  - ptr <= (w+1) mod NB_IN. If w=NB_IN-1, ptr wraps to 0.
  - Without an accept, ptr holds.
- Memory stall (out.gnt=0):
  - ptr holds; no grant is issued.
  - Requesters keep req asserted per the TCDM protocol.
  - The winner may change if a higher-priority requester raises req in the meantime. This is allowed.
- In-flight pipeline:
  - RESP_LATENCY-stage shift register of {valid, idx}; stage 0 is loaded with {accept, w} every cycle.
  - The last stage tags the current out.r_valid.
- Response routing:
  - in[i].r_valid = out.r_valid & tail.valid & (tail.idx==i).
  - in[i].r_data = out.r_data broadcast to all ports.
- Writes also produce r_valid, and are routed identically.
- out.r_valid=1 with tail.valid=0: the response is dropped and err_o <= 1. err_o stays high until reset or clear.
- busy_o = OR of all pipeline valid bits.
- Back-to-back accepts from different requesters, one per cycle, are supported at full throughput. Responses return in acceptance order.
- enable_i falling mid-operation: new requests stop immediately; in-flight responses still route correctly.
- Reset during outstanding transactions discards the tags. Later memory responses set err_o; this is documented, not a bug.
- Index width: IDX_W = $clog2(NB_IN). Pointer arithmetic wraps explicitly; it must not rely on power-of-two NB_IN.

Decomposition:
- Shared package hwpe_stream_package holds:
  - typedef tcdm_inflight_t {logic valid; logic [IDX_W-1:0] idx}, parameterized via localparam in the module.
  - Constant HWPE_TCDM_RESP_LATENCY_DEFAULT = 1.
- One sub-module: hwpe_stream_rr_pick.
  - Combinational round-robin picker.
  - Inputs: req vector, ptr. Outputs: winner index, winner valid.
  - Reused by future arbiters.
- Pipeline and pointer registers stay in the top module.

Test Plan:
- Single requester: in[1] reads add=0x10 with out.gnt=1 and memory word 0xDEADBEEF → in[1].gnt high same cycle; in[1].r_valid and r_data=0xDEADBEEF after 1 cycle; in[0].r_valid stays 0.
- NB_IN=3, all three req continuously, out.gnt=1 → grant order 0,1,2,0,1,2. Each r_valid routes to its own port one cycle later. busy_o stays 1 throughout.
- Stall: req on in[0] and in[2], out.gnt=0 for 3 cycles, then 1 → no in.gnt during the stall; ptr unchanged; in[0] granted first, in[2] next cycle.
- RESP_LATENCY=3, write to 0x20 data 0x12345678 by in[1], then read of 0x20 by in[0] → in[1].r_valid after 3 cycles; in[0] reads 0x12345678 after 3 cycles; order preserved.
- Spurious response: force out.r_valid=1 with no accept → no in.r_valid; err_o=1 from the next cycle until clear_i pulse, then 0.
- Reset mid-stream: drop rst_ni for 1 cycle while 2 responses are in flight → ptr=0, busy_o=0, next grant goes to lowest active index.
